lane_deserializer: RTL and testbench

//  Downstream stage of the 1:2 bit demux. Consumes its two lane outputs plus the

---
 rtl/deser_pkg.sv | 19 +
 rtl/lane_deserializer_lane.sv | 95 +++++++++
 rtl/lane_deserializer.sv | 54 +++++
 tb/tb_lane_deserializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants for the two-lane bit deserializer.
package deser_pkg;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   localparam int OVR_LANE0 = 0;
   localparam int OVR_LANE1 = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } lane_state_e;

   function automatic int cnt_width(input int word_w);
      return (word_w > 1) ? $clog2(word_w) : 1;
   endfunction

endpackage

// File: rtl/lane_deserializer_lane.sv
// One deserializer lane: shifter, bit counter, held output word and overrun flag.
//
//  state    | meaning
//  ST_IDLE  | cnt_q == 0, no partial bits held
//  ST_ACCUM | 0 < cnt_q < WORD_W, partial word in shift_q
module lane_deser
   import deser_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_valid_i,
   input  logic              bit_i,
   input  logic              flush_i,
   input  logic              ready_i,
   output logic [WORD_W-1:0] data_o,
   output logic              valid_o,
   output logic              overrun_o
);

   localparam int               CNT_W = cnt_width(WORD_W);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_W - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic [WORD_W-1:0] word_new;
   logic              complete;
   lane_state_e       state;

   assign state = (cnt_q == '0) ? ST_IDLE : ST_ACCUM;

   always_comb begin
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      complete = 1'b0;

      if (MSB_FIRST) word_new = {shift_q[WORD_W-2:0], bit_i};
      else           word_new = {bit_i, shift_q[WORD_W-1:1]};

      if (valid_q && ready_i) valid_d = 1'b0;

      // flush beats a same-cycle bit so nothing from before it survives
      if (flush_i) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (bit_valid_i) begin
         if (state == ST_ACCUM && cnt_q == LAST) begin
            cnt_d    = '0;
            shift_d  = '0;
            complete = 1'b1;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = word_new;
         end
      end

      if (complete) begin
         if (valid_q && !ready_i) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = word_new;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/lane_deserializer.sv
// Two-lane deserializer behind a 1:2 bit demux; steers each bit to its lane by sel.
module lane_deserializer
   import deser_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_valid,
   input  logic              sel,
   input  logic              lane0_bit,
   input  logic              lane1_bit,
   input  logic              flush,
   output logic [WORD_W-1:0] word0_data,
   output logic              word0_valid,
   input  logic              word0_ready,
   output logic [WORD_W-1:0] word1_data,
   output logic              word1_valid,
   input  logic              word1_ready,
   output logic              overrun0,
   output logic              overrun1
);

   logic [1:0] ovr;

   lane_deser #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_lane0 (
      .clk         (clk),
      .reset       (reset),
      .bit_valid_i (bit_valid && (sel == LANE0)),
      .bit_i       (lane0_bit),
      .flush_i     (flush),
      .ready_i     (word0_ready),
      .data_o      (word0_data),
      .valid_o     (word0_valid),
      .overrun_o   (ovr[OVR_LANE0])
   );

   lane_deser #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_lane1 (
      .clk         (clk),
      .reset       (reset),
      .bit_valid_i (bit_valid && (sel == LANE1)),
      .bit_i       (lane1_bit),
      .flush_i     (flush),
      .ready_i     (word1_ready),
      .data_o      (word1_data),
      .valid_o     (word1_valid),
      .overrun_o   (ovr[OVR_LANE1])
   );

   assign overrun0 = ovr[OVR_LANE0];
   assign overrun1 = ovr[OVR_LANE1];

endmodule

// File: tb/tb_lane_deserializer.sv
// Scoreboard bench for lane_deserializer; an LSB-first twin shares all stimulus.
module tb_lane_deserializer;

   logic       clk = 1'b0;
   logic       reset, bit_valid, sel, lane0_bit, lane1_bit, flush;
   logic       word0_ready, word1_ready;
   logic [7:0] word0_data, word1_data, word0_data_b, word1_data_b;
   logic       word0_valid, word1_valid, word0_valid_b, word1_valid_b;
   logic       overrun0, overrun1, overrun0_b, overrun1_b;

   int total = 0;
   int bad   = 0;
   logic [7:0] q0[$], q1[$], qb0[$], qb1[$];

   always #5 clk = ~clk;

   lane_deserializer #(.WORD_W(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .sel(sel),
      .lane0_bit(lane0_bit), .lane1_bit(lane1_bit), .flush(flush),
      .word0_data(word0_data), .word0_valid(word0_valid), .word0_ready(word0_ready),
      .word1_data(word1_data), .word1_valid(word1_valid), .word1_ready(word1_ready),
      .overrun0(overrun0), .overrun1(overrun1)
   );

   lane_deserializer #(.WORD_W(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .sel(sel),
      .lane0_bit(lane0_bit), .lane1_bit(lane1_bit), .flush(flush),
      .word0_data(word0_data_b), .word0_valid(word0_valid_b), .word0_ready(word0_ready),
      .word1_data(word1_data_b), .word1_valid(word1_valid_b), .word1_ready(word1_ready),
      .overrun0(overrun0_b), .overrun1(overrun1_b)
   );

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_word(input logic lane, input logic [7:0] w);
      if (lane == 1'b0) begin
         q0.push_back(w);
         qb0.push_back(rev8(w));
      end else begin
         q1.push_back(w);
         qb1.push_back(rev8(w));
      end
   endtask

   // Each transfer (valid & ready at the falling edge) pops one expected word.
   always @(negedge clk) begin
      if (!reset) begin
         if (word0_valid && word0_ready) begin
            if (q0.size() == 0) check("w0_unexpected", 32'(word0_data), 32'hFFFF_FFFF);
            else check("w0_data", 32'(word0_data), 32'(q0.pop_front()));
         end
         if (word1_valid && word1_ready) begin
            if (q1.size() == 0) check("w1_unexpected", 32'(word1_data), 32'hFFFF_FFFF);
            else check("w1_data", 32'(word1_data), 32'(q1.pop_front()));
         end
         if (word0_valid_b && word0_ready) begin
            if (qb0.size() == 0) check("lsb_w0_unexpected", 32'(word0_data_b), 32'hFFFF_FFFF);
            else check("lsb_w0_data", 32'(word0_data_b), 32'(qb0.pop_front()));
         end
         if (word1_valid_b && word1_ready) begin
            if (qb1.size() == 0) check("lsb_w1_unexpected", 32'(word1_data_b), 32'hFFFF_FFFF);
            else check("lsb_w1_data", 32'(word1_data_b), 32'(qb1.pop_front()));
         end
      end
   end

   // The unselected lane gets the complement so a steering bug corrupts words.
   task automatic cycle(input logic bv, input logic s, input logic b, input logic fl);
      bit_valid = bv;
      sel       = s;
      lane0_bit = (s == 1'b0) ? b : ~b;
      lane1_bit = (s == 1'b1) ? b : ~b;
      flush     = fl;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic send_bits(input logic lane, input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, lane, w[7-i], 1'b0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      reset = 1'b1; bit_valid = 1'b0; sel = 1'b0; lane0_bit = 1'b0; lane1_bit = 1'b0;
      flush = 1'b0; word0_ready = 1'b1; word1_ready = 1'b1;
      apply_reset();
      check("rst_valid0", 32'(word0_valid), 32'd0);
      check("rst_valid1", 32'(word1_valid), 32'd0);
      check("rst_data0", 32'(word0_data), 32'd0);
      check("rst_ovr", 32'({overrun0, overrun1}), 32'd0);

      // 1: single lane0 word, latency 1
      expect_word(1'b0, 8'hA5);
      send_bits(1'b0, 8'hA5, 7);
      check("t1_not_early", 32'(word0_valid), 32'd0);
      w = 8'hA5;
      cycle(1'b1, 1'b0, w[0], 1'b0);
      check("t1_valid0", 32'(word0_valid), 32'd1);
      check("t1_valid1_low", 32'(word1_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // 2: interleaved lanes
      expect_word(1'b0, 8'h3C);
      expect_word(1'b1, 8'hC3);
      for (int i = 0; i < 8; i++) begin
         w = 8'h3C;
         cycle(1'b1, 1'b0, w[7-i], 1'b0);
         if (i == 7) begin
            check("t2_valid0", 32'(word0_valid), 32'd1);
            check("t2_valid1_early", 32'(word1_valid), 32'd0);
         end
         w = 8'hC3;
         cycle(1'b1, 1'b1, w[7-i], 1'b0);
      end
      check("t2_valid1", 32'(word1_valid), 32'd1);
      check("t2_valid0_taken", 32'(word0_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // 3: overrun while held
      word0_ready = 1'b0;
      expect_word(1'b0, 8'h11);
      send_bits(1'b0, 8'h11, 8);
      check("t3_held_valid", 32'(word0_valid), 32'd1);
      check("t3_no_ovr_yet", 32'(overrun0), 32'd0);
      send_bits(1'b0, 8'h22, 8);
      check("t3_data_kept", 32'(word0_data), 32'h11);
      check("t3_ovr0", 32'(overrun0), 32'd1);
      check("t3_lsb_ovr0", 32'(overrun0_b), 32'd1);
      check("t3_ovr1_clear", 32'(overrun1), 32'd0);
      word0_ready = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("t3_valid_dropped", 32'(word0_valid), 32'd0);
      check("t3_ovr_sticky", 32'(overrun0), 32'd1);

      // 4: completion on the same cycle as a transfer
      apply_reset();
      check("t4_rst_ovr", 32'(overrun0), 32'd0);
      word0_ready = 1'b0;
      expect_word(1'b0, 8'h44);
      send_bits(1'b0, 8'h44, 8);
      expect_word(1'b0, 8'h55);
      send_bits(1'b0, 8'h55, 7);
      word0_ready = 1'b1;
      w = 8'h55;
      cycle(1'b1, 1'b0, w[0], 1'b0);
      check("t4_valid_stays", 32'(word0_valid), 32'd1);
      check("t4_data", 32'(word0_data), 32'h55);
      check("t4_no_ovr", 32'(overrun0), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // 5: reset and flush drop partial words; flush keeps the output stage
      send_bits(1'b0, 8'hFF, 5);
      apply_reset();
      word0_ready = 1'b0;
      expect_word(1'b0, 8'hF0);
      send_bits(1'b0, 8'hF0, 8);
      send_bits(1'b0, 8'hFF, 5);
      send_bits(1'b1, 8'hFF, 3);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      check("t5_flush_valid", 32'(word0_valid), 32'd1);
      check("t5_flush_data", 32'(word0_data), 32'hF0);
      check("t5_flush_ovr", 32'(overrun0), 32'd0);
      word0_ready = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      expect_word(1'b0, 8'h0F);
      send_bits(1'b0, 8'h0F, 8);
      expect_word(1'b1, 8'h5A);
      send_bits(1'b1, 8'h5A, 8);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // 6: bit order, MSB-first vs LSB-first twin
      expect_word(1'b0, 8'hC0);
      send_bits(1'b0, 8'hC0, 8);
      check("t6_msb_first", 32'(word0_data), 32'hC0);
      check("t6_lsb_first", 32'(word0_data_b), 32'h03);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      check("qb0_drained", 32'(qb0.size()), 32'd0);
      check("qb1_drained", 32'(qb1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
